sram_axi_bridge: RTL and testbench
==================================

# sram_axi_bridge

Converts the core's two SRAM-like master ports (instruction fetch and data memory) into a single AXI3 master port toward the SoC interconnect. It sits directly downstream of the pipeline top. It arbitrates between the two requesters and serializes all traffic with exactly one transaction in flight. Each accepted request becomes either one single-beat AXI read, or one single-beat AXI write followed by its write response.

## Interface
- No parameters. ID, length and attribute fields are fixed (see Operation).
- clk  in  1  clock.
- resetn  in  1  synchronous, active-low reset.
- inst_req, inst_wr  in  1 each  instruction-side request / write flag.
- inst_size  in  2  0 = byte, 1 = half, 2 = word.
- inst_addr, inst_wdata  in  32 each  byte address / write data.
- inst_addr_ok, inst_data_ok  out  1 each  request accepted / response valid (single-cycle pulses).
- inst_rdata  out  32  read data, valid while inst_data_ok = 1.
- data_req, data_wr, data_size, data_addr, data_wdata, data_addr_ok, data_data_ok, data_rdata: data-side ports, with the same directions, widths and meanings as the inst_* ports.
- arid 4, araddr 32, arlen 8, arsize 3, arburst 2, arlock 2, arcache 4, arprot 3, arvalid 1  out; arready 1  in.
- rid 4, rdata 32, rresp 2, rlast 1, rvalid 1  in; rready 1  out.
- awid 4, awaddr 32, awlen 8, awsize 3, awburst 2, awlock 2, awcache 4, awprot 3, awvalid 1  out; awready 1  in.
- wid 4, wdata 32, wstrb 4, wlast 1, wvalid 1  out; wready 1  in.
- bid 4, bresp 2, bvalid 1  in; bready 1  out.

## Operation
- State machine: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP.
- **IDLE arbitration**
  - data_req = 1: data_addr_ok = 1 (combinational); the data request is accepted.
  - Otherwise, inst_req = 1: inst_addr_ok = 1 (combinational); the inst request is accepted.
  - In all other states both addr_ok outputs are 0.
- **On accept**, register: source (inst or data), wr, size, addr, wdata. Next state is WR_REQ if wr = 1, else RD_ADDR.
- **RD_ADDR**
  - arvalid = 1, araddr = latched addr, arsize = {1'b0, size}, arid = 0 for inst and 1 for data.
  - On arready, go to RD_DATA.
- **RD_DATA**
  - rready = 1.
  - On rvalid: the selected source's data_ok = 1 and its rdata = AXI rdata, both combinational in that cycle; go to IDLE.
- **WR_REQ**
  - awvalid and wvalid are both asserted on entry.
  - Each drops independently after its own handshake (tracked by aw_done / w_done flags).
  - When both handshakes are complete (same cycle or different cycles), go to WR_RESP.
  - awid = wid = 1; wdata = latched wdata; wlast = 1.
- **wstrb**
  - size 0: 4'b0001 << addr[1:0].
  - size 1: 4'b0011 << {addr[1], 1'b0}.
  - size 2: 4'b1111.
- **WR_RESP**
  - bready = 1.
  - On bvalid: the source's data_ok = 1 for one cycle (rdata don't-care); go to IDLE.
- **Fixed fields:** arlen/awlen = 0, arburst/awburst = 2'b01, lock = 0, cache = 0, prot = 0.
- **Ignored inputs:** rresp, bresp, rid, bid, rlast.
- **Handshake discipline:** a valid, once raised, is never dropped and its payload never changes before the matching ready.
- rready is only asserted in RD_DATA and bready only in WR_RESP. Stray rvalid/bvalid in any other state is not consumed.
- inst_rdata and data_rdata are both driven from AXI rdata; only the data_ok qualifies which one is meaningful.

## Timing
- **Reset:** resetn = 0 at a clk edge puts the block in IDLE and clears aw_done/w_done.
  - All valid/ready/addr_ok/data_ok outputs read 0 while resetn is low and after reset.
  - Address, wdata and strobe outputs read 0.
- **Reset mid-transaction:** the transaction is abandoned with no data_ok. The interconnect shares resetn and is reset with the bridge.
- **Minimum read latency:** accept at cycle T; arvalid at T+1; arready at T+1 gives rready at T+2; rvalid at T+2 gives data_ok at T+2.
- **Minimum write latency:** accept at T; aw/w valid at T+1; both ready at T+1; bready at T+2; data_ok at T+2.
- **Back-to-back:** the earliest next acceptance is the cycle after data_ok. Sustained single-beat throughput is one transaction per 3 cycles.
- **Simultaneous inst_req and data_req in IDLE:** data wins. inst_req is not granted in that cycle but is eligible again the next time the block reaches IDLE; the requester must hold it.

## Test plan
- **Word read, zero-wait slave.** inst_req at T, addr 0xBFC00000.
  - Required: inst_addr_ok at T; arvalid at T+1 with arid 0 and arsize 2.
  - rdata 0x3C1DBFC0 at T+2 gives inst_data_ok = 1 and inst_rdata = 0x3C1DBFC0 for that single cycle.
- **Contention.** inst_req and data_req both high at T (data read, addr 0x80001000).
  - Required: data_addr_ok = 1 and inst_addr_ok = 0 at T.
  - Inst is accepted in the cycle after data_data_ok; AR order is arid 1, then arid 0.
- **Byte store, split handshakes.** data_wr with size 0, addr 0x80000003, wdata 0x000000AB.
  - Slave gives wready 2 cycles before awready.
  - Required: wstrb = 4'b1000; wvalid drops after its handshake while awvalid holds; bready only after both handshakes.
  - Exactly one data_data_ok, on bvalid.
- **Halfword store strobe.** size 1, addr 0x80000002.
  - Required: wstrb = 4'b1100, awsize = 1.
- **Slave backpressure.** arready is held low 5 cycles, then rvalid is delayed 3 cycles.
  - Required: arvalid and araddr stay stable throughout; no addr_ok to either port until data_ok.
- **Reset mid-read.** resetn low while in RD_DATA.
  - Required: outputs zero next cycle and no data_ok.
  - After reset release, a new inst_req is accepted in IDLE.

Source files
------------

// File: rtl/sram_axi_bridge_if.sv
// AXI3 single-beat bus between the SRAM bridge (master) and the SoC interconnect (slave).
interface sram_axi_bridge_if;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [1:0]  arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;

    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic [1:0]  awlock;
    logic [3:0]  awcache;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;

    logic [3:0]  wid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;

    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );
endinterface

// File: rtl/sram_axi_bridge.sv
// Arbitrates the core's inst/data SRAM-like ports onto one AXI3 master,
// with exactly one single-beat transaction in flight at a time.
module sram_axi_bridge (
    input  logic        clk,
    input  logic        resetn,

    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    sram_axi_bridge_if.master axi
);
    // state   | meaning
    // IDLE    | waiting for a request; data side has priority
    // RD_ADDR | AR channel valid, waiting for arready
    // RD_DATA | rready high, waiting for rvalid
    // WR_REQ  | AW and W valid, each dropped after its own handshake
    // WR_RESP | bready high, waiting for bvalid
    typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP} state_t;

    state_t      state_q;
    logic        src_q;          // 1 = data port, 0 = inst port
    logic [1:0]  size_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        aw_done_q;
    logic        w_done_q;

    logic        live;
    logic        accept;
    logic        aw_ok;
    logic        w_ok;
    logic        resp;
    logic [3:0]  strb;
    logic        unused_axi;

    // Every handshake output is masked while resetn is low, not just after the edge.
    assign live         = resetn;
    assign data_addr_ok = live && (state_q == IDLE) && data_req;
    assign inst_addr_ok = live && (state_q == IDLE) && !data_req && inst_req;
    assign accept       = data_addr_ok || inst_addr_ok;

    assign aw_ok = aw_done_q || (axi.awvalid && axi.awready);
    assign w_ok  = w_done_q  || (axi.wvalid  && axi.wready);

    assign resp = live && (((state_q == RD_DATA) && axi.rvalid) ||
                           ((state_q == WR_RESP) && axi.bvalid));
    assign inst_data_ok = resp && !src_q;
    assign data_data_ok = resp && src_q;
    assign inst_rdata   = axi.rdata;
    assign data_rdata   = axi.rdata;

    always_comb begin
        strb = 4'b1111;
        case (size_q)
            2'd0:    strb = 4'b0001 << addr_q[1:0];
            2'd1:    strb = 4'b0011 << {addr_q[1], 1'b0};
            default: strb = 4'b1111;
        endcase
    end

    assign axi.arid    = {3'b000, src_q};
    assign axi.araddr  = live ? addr_q : 32'd0;
    assign axi.arlen   = 8'd0;
    assign axi.arsize  = {1'b0, size_q};
    assign axi.arburst = 2'b01;
    assign axi.arlock  = 2'b00;
    assign axi.arcache = 4'd0;
    assign axi.arprot  = 3'd0;
    assign axi.arvalid = live && (state_q == RD_ADDR);
    assign axi.rready  = live && (state_q == RD_DATA);

    assign axi.awid    = 4'd1;
    assign axi.awaddr  = live ? addr_q : 32'd0;
    assign axi.awlen   = 8'd0;
    assign axi.awsize  = {1'b0, size_q};
    assign axi.awburst = 2'b01;
    assign axi.awlock  = 2'b00;
    assign axi.awcache = 4'd0;
    assign axi.awprot  = 3'd0;
    assign axi.awvalid = live && (state_q == WR_REQ) && !aw_done_q;

    assign axi.wid     = 4'd1;
    assign axi.wdata   = live ? wdata_q : 32'd0;
    assign axi.wstrb   = live ? strb : 4'd0;
    assign axi.wlast   = 1'b1;
    assign axi.wvalid  = live && (state_q == WR_REQ) && !w_done_q;
    assign axi.bready  = live && (state_q == WR_RESP);

    assign unused_axi = &{1'b0, axi.rid, axi.rresp, axi.rlast, axi.bid, axi.bresp};

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= IDLE;
            src_q     <= 1'b0;
            size_q    <= 2'd0;
            addr_q    <= 32'd0;
            wdata_q   <= 32'd0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        src_q   <= data_req;
                        size_q  <= data_req ? data_size  : inst_size;
                        addr_q  <= data_req ? data_addr  : inst_addr;
                        wdata_q <= data_req ? data_wdata : inst_wdata;
                        state_q <= (data_req ? data_wr : inst_wr) ? WR_REQ : RD_ADDR;
                    end
                end
                RD_ADDR: if (axi.arready) state_q <= RD_DATA;
                RD_DATA: if (axi.rvalid)  state_q <= IDLE;
                WR_REQ: begin
                    if (axi.awvalid && axi.awready) aw_done_q <= 1'b1;
                    if (axi.wvalid && axi.wready)   w_done_q  <= 1'b1;
                    if (aw_ok && w_ok) begin
                        state_q   <= WR_RESP;
                        aw_done_q <= 1'b0;
                        w_done_q  <= 1'b0;
                    end
                end
                WR_RESP: if (axi.bvalid) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sram_axi_bridge.sv
// Directed bench for sram_axi_bridge: the bench plays the AXI slave cycle by cycle.
module tb_sram_axi_bridge;
    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_req, inst_wr;
    logic [1:0]  inst_size;
    logic [31:0] inst_addr, inst_wdata;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;

    int checks = 0;
    int errors = 0;

    sram_axi_bridge_if axi ();

    sram_axi_bridge dut (
        .clk          (clk),
        .resetn       (resetn),
        .inst_req     (inst_req),
        .inst_wr      (inst_wr),
        .inst_size    (inst_size),
        .inst_addr    (inst_addr),
        .inst_wdata   (inst_wdata),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .axi          (axi.master)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs are driven here.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        resetn = 1'b0;
        inst_req = 0; inst_wr = 0; inst_size = 2'd2; inst_addr = 0; inst_wdata = 0;
        data_req = 0; data_wr = 0; data_size = 2'd2; data_addr = 0; data_wdata = 0;
        axi.arready = 0; axi.rvalid = 0; axi.rdata = 0; axi.rid = 0; axi.rresp = 0; axi.rlast = 1;
        axi.awready = 0; axi.wready = 0; axi.bvalid = 0; axi.bid = 0; axi.bresp = 0;

        step(); step();
        #1;
        chk("rst_arvalid", {31'd0, axi.arvalid}, 32'd0);
        chk("rst_awvalid", {31'd0, axi.awvalid}, 32'd0);
        chk("rst_wvalid", {31'd0, axi.wvalid}, 32'd0);
        chk("rst_rready", {31'd0, axi.rready}, 32'd0);
        chk("rst_bready", {31'd0, axi.bready}, 32'd0);
        chk("rst_addr_ok", {30'd0, inst_addr_ok, data_addr_ok}, 32'd0);
        chk("rst_data_ok", {30'd0, inst_data_ok, data_data_ok}, 32'd0);
        chk("rst_araddr", axi.araddr, 32'd0);
        chk("rst_awaddr", axi.awaddr, 32'd0);
        chk("rst_wdata", axi.wdata, 32'd0);
        chk("rst_wstrb", {28'd0, axi.wstrb}, 32'd0);
        resetn = 1'b1;

        // Word read, zero-wait slave
        step();
        inst_req = 1; inst_wr = 0; inst_size = 2'd2; inst_addr = 32'hBFC00000;
        #1;
        chk("rd_inst_addr_ok", {31'd0, inst_addr_ok}, 32'd1);
        chk("rd_data_addr_ok", {31'd0, data_addr_ok}, 32'd0);
        step();
        inst_req = 0; axi.arready = 1;
        #1;
        chk("rd_arvalid", {31'd0, axi.arvalid}, 32'd1);
        chk("rd_arid", {28'd0, axi.arid}, 32'd0);
        chk("rd_arsize", {29'd0, axi.arsize}, 32'd2);
        chk("rd_araddr", axi.araddr, 32'hBFC00000);
        chk("rd_arlen", {24'd0, axi.arlen}, 32'd0);
        chk("rd_arburst", {30'd0, axi.arburst}, 32'd1);
        chk("rd_rready_early", {31'd0, axi.rready}, 32'd0);
        step();
        axi.arready = 0; axi.rvalid = 1; axi.rdata = 32'h3C1DBFC0;
        #1;
        chk("rd_rready", {31'd0, axi.rready}, 32'd1);
        chk("rd_inst_data_ok", {31'd0, inst_data_ok}, 32'd1);
        chk("rd_inst_rdata", inst_rdata, 32'h3C1DBFC0);
        chk("rd_data_data_ok", {31'd0, data_data_ok}, 32'd0);
        step();
        axi.rvalid = 0;
        #1;
        chk("rd_data_ok_pulse", {31'd0, inst_data_ok}, 32'd0);
        chk("rd_rready_idle", {31'd0, axi.rready}, 32'd0);

        // Contention: data wins, inst held and served afterwards
        inst_req = 1; inst_addr = 32'hBFC00004;
        data_req = 1; data_wr = 0; data_size = 2'd2; data_addr = 32'h80001000;
        #1;
        chk("ct_data_addr_ok", {31'd0, data_addr_ok}, 32'd1);
        chk("ct_inst_addr_ok", {31'd0, inst_addr_ok}, 32'd0);
        step();
        data_req = 0; axi.arready = 1;
        #1;
        chk("ct_arid_first", {28'd0, axi.arid}, 32'd1);
        chk("ct_araddr_first", axi.araddr, 32'h80001000);
        chk("ct_inst_wait", {31'd0, inst_addr_ok}, 32'd0);
        step();
        axi.arready = 0; axi.rvalid = 1; axi.rdata = 32'h11112222;
        #1;
        chk("ct_data_data_ok", {31'd0, data_data_ok}, 32'd1);
        chk("ct_data_rdata", data_rdata, 32'h11112222);
        chk("ct_inst_not_ok", {30'd0, inst_data_ok, inst_addr_ok}, 32'd0);
        step();
        axi.rvalid = 0;
        #1;
        chk("ct_inst_accept", {31'd0, inst_addr_ok}, 32'd1);
        step();
        inst_req = 0; axi.arready = 1;
        #1;
        chk("ct_arid_second", {28'd0, axi.arid}, 32'd0);
        chk("ct_araddr_second", axi.araddr, 32'hBFC00004);
        step();
        axi.arready = 0; axi.rvalid = 1; axi.rdata = 32'h00000055;
        #1;
        chk("ct_inst_data_ok", {31'd0, inst_data_ok}, 32'd1);
        chk("ct_inst_rdata", inst_rdata, 32'h00000055);
        step();
        axi.rvalid = 0;

        // Byte store, W accepted two cycles before AW
        data_req = 1; data_wr = 1; data_size = 2'd0; data_addr = 32'h80000003; data_wdata = 32'h000000AB;
        #1;
        chk("bs_addr_ok", {31'd0, data_addr_ok}, 32'd1);
        step();
        data_req = 0; axi.wready = 1; axi.awready = 0;
        #1;
        chk("bs_valids", {30'd0, axi.awvalid, axi.wvalid}, 32'd3);
        chk("bs_wstrb", {28'd0, axi.wstrb}, 32'h8);
        chk("bs_wdata", axi.wdata, 32'h000000AB);
        chk("bs_wlast", {31'd0, axi.wlast}, 32'd1);
        chk("bs_ids", {24'd0, axi.awid, axi.wid}, 32'h11);
        chk("bs_awsize", {29'd0, axi.awsize}, 32'd0);
        chk("bs_awaddr", axi.awaddr, 32'h80000003);
        step();
        axi.wready = 0;
        #1;
        chk("bs_w_dropped", {30'd0, axi.awvalid, axi.wvalid}, 32'd2);
        chk("bs_bready_early1", {31'd0, axi.bready}, 32'd0);
        step();
        axi.awready = 1;
        #1;
        chk("bs_aw_held", {30'd0, axi.awvalid, axi.wvalid}, 32'd2);
        chk("bs_bready_early2", {31'd0, axi.bready}, 32'd0);
        chk("bs_no_ok_early", {31'd0, data_data_ok}, 32'd0);
        step();
        axi.awready = 0;
        #1;
        chk("bs_aw_dropped", {30'd0, axi.awvalid, axi.wvalid}, 32'd0);
        chk("bs_bready", {31'd0, axi.bready}, 32'd1);
        chk("bs_no_ok_wait_b", {31'd0, data_data_ok}, 32'd0);
        step();
        axi.bvalid = 1;
        #1;
        chk("bs_data_ok", {31'd0, data_data_ok}, 32'd1);
        chk("bs_inst_ok", {31'd0, inst_data_ok}, 32'd0);
        step();
        axi.bvalid = 0;
        #1;
        chk("bs_data_ok_pulse", {31'd0, data_data_ok}, 32'd0);
        chk("bs_bready_idle", {31'd0, axi.bready}, 32'd0);

        // Halfword store, both handshakes in the same cycle
        data_req = 1; data_wr = 1; data_size = 2'd1; data_addr = 32'h80000002; data_wdata = 32'hBEEF0000;
        step();
        data_req = 0; axi.awready = 1; axi.wready = 1;
        #1;
        chk("hs_wstrb", {28'd0, axi.wstrb}, 32'hC);
        chk("hs_awsize", {29'd0, axi.awsize}, 32'd1);
        chk("hs_valids", {30'd0, axi.awvalid, axi.wvalid}, 32'd3);
        step();
        axi.awready = 0; axi.wready = 0; axi.bvalid = 1;
        #1;
        chk("hs_bready", {31'd0, axi.bready}, 32'd1);
        chk("hs_data_ok", {31'd0, data_data_ok}, 32'd1);
        step();
        axi.bvalid = 0;

        // Slave backpressure on AR then R, with both requesters pushing
        inst_req = 1; inst_wr = 0; inst_size = 2'd2; inst_addr = 32'hBFC00100;
        #1;
        chk("bp_accept", {31'd0, inst_addr_ok}, 32'd1);
        step();
        data_req = 1; data_wr = 0; data_addr = 32'h80002000;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_arvalid", {31'd0, axi.arvalid}, 32'd1);
            chk("bp_araddr", axi.araddr, 32'hBFC00100);
            chk("bp_addr_ok", {30'd0, inst_addr_ok, data_addr_ok}, 32'd0);
            step();
        end
        axi.arready = 1;
        #1;
        chk("bp_arvalid_hs", {31'd0, axi.arvalid}, 32'd1);
        step();
        axi.arready = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_rready", {31'd0, axi.rready}, 32'd1);
            chk("bp_no_data_ok", {30'd0, inst_data_ok, data_data_ok}, 32'd0);
            chk("bp_addr_ok_r", {30'd0, inst_addr_ok, data_addr_ok}, 32'd0);
            step();
        end
        axi.rvalid = 1; axi.rdata = 32'hCAFEF00D;
        #1;
        chk("bp_data_ok", {31'd0, inst_data_ok}, 32'd1);
        chk("bp_rdata", inst_rdata, 32'hCAFEF00D);
        inst_req = 0; data_req = 0;
        step();
        axi.rvalid = 0;

        // Reset while in RD_DATA
        inst_req = 1; inst_addr = 32'h00001000;
        step();
        inst_req = 0; axi.arready = 1;
        step();
        axi.arready = 0;
        #1;
        chk("mr_rready", {31'd0, axi.rready}, 32'd1);
        resetn = 0; axi.rvalid = 1; axi.rdata = 32'h12345678;
        #1;
        chk("mr_low_rready", {31'd0, axi.rready}, 32'd0);
        chk("mr_low_data_ok", {30'd0, inst_data_ok, data_data_ok}, 32'd0);
        step();
        axi.rvalid = 0;
        #1;
        chk("mr_after_valids", {28'd0, axi.arvalid, axi.rready, axi.awvalid, axi.bready}, 32'd0);
        chk("mr_after_araddr", axi.araddr, 32'd0);
        chk("mr_after_data_ok", {30'd0, inst_data_ok, data_data_ok}, 32'd0);
        resetn = 1;
        step();
        inst_req = 1; inst_addr = 32'h00002000;
        #1;
        chk("mr_new_accept", {31'd0, inst_addr_ok}, 32'd1);
        step();
        inst_req = 0; axi.arready = 1;
        #1;
        chk("mr_new_araddr", axi.araddr, 32'h00002000);
        step();
        axi.arready = 0; axi.rvalid = 1; axi.rdata = 32'h0BADF00D;
        #1;
        chk("mr_new_data_ok", {31'd0, inst_data_ok}, 32'd1);
        chk("mr_new_rdata", inst_rdata, 32'h0BADF00D);
        step();
        axi.rvalid = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
